// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect and decode handoff.
// Latency: none (wires only).
// Backpressure: imem_req_ready stalls requests, instr_ready holds the decode handoff.
interface instr_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr_data;
    logic [WIDTH-1:0] instr_pc;

    // Fetch unit side
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_target,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_target,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the PC, issues one outstanding imem request, hands word+PC to decode.
// Latency: 3 cycles minimum per instruction (request accepted, response, decode handshake).
// Backpressure: waits on imem_req_ready and instr_ready; FETCH_MISALIGN_CHECK_EN adds a sticky misalign halt.
module instr_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst_n,
    instr_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic misalign_fault
`endif
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        DROP,
        OUT
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        HALT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      data_q, data_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic             req_vld;
    logic             out_vld;
    logic             fault_q, fault_d;

    // State, PC and captured instruction registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            data_q  <= '0;
            ipc_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and output decode; redirect wins over every other event
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        data_d  = data_q;
        ipc_d   = ipc_q;
        fault_d = fault_q;
        req_vld = 1'b0;
        out_vld = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = REQ;
                if (bus.redirect_valid) pc_d = bus.redirect_target;
            end
            REQ: begin
                req_vld = 1'b1;
                if (bus.redirect_valid) begin
                    // A request accepted this cycle is already stale
                    pc_d    = bus.redirect_target;
                    state_d = bus.imem_req_ready ? DROP : REQ;
                end else if (bus.imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_target;
                    state_d = bus.imem_rsp_valid ? REQ : DROP;
                end else if (bus.imem_rsp_valid) begin
                    data_d  = bus.imem_rsp_data;
                    ipc_d   = pc_q;
                    state_d = OUT;
                end
            end
            DROP: begin
                if (bus.redirect_valid) pc_d = bus.redirect_target;
                if (bus.imem_rsp_valid) state_d = REQ;
            end
            OUT: begin
                out_vld = 1'b1;
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_target;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + WIDTH'(4);
                    state_d = REQ;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            HALT: begin
                // Parked until reset; any late response is simply ignored
                state_d = HALT;
            end
`endif
            default: state_d = BOOT;
        endcase

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned target overrides whatever the state decode chose
        if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            pc_d    = bus.redirect_target;
            state_d = HALT;
        end
`endif
    end

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = out_vld;
    assign bus.instr_data     = data_q;
    assign bus.instr_pc       = ipc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_fault = fault_q;
`else
    // Fault flag has no consumer without the misalign check
    logic unused_fault;
    assign unused_fault = fault_q ^ fault_d;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, decode stall, redirects, wrap, reset.
// Inputs driven on the falling edge, outputs checked on the following falling edge.
// Memory responses are driven by hand, one cycle or later after acceptance.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    instr_fetch_unit_if #(.WIDTH(32)) bus ();

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_fault;
`endif

    instr_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, land on the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.instr_ready     = 1'b0;

        @(negedge clk);
        step();
        chk("rst_req_vld",   32'(bus.imem_req_valid), 32'h0);
        chk("rst_instr_vld", 32'(bus.instr_valid),    32'h0);
        chk("rst_addr",      bus.imem_req_addr,       32'h0);
        chk("rst_data",      bus.instr_data,          32'h0);
        chk("rst_pc",        bus.instr_pc,            32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_fault",     32'(misalign_fault),     32'h0);
`endif

        // Leave reset: BOOT then REQ
        rst_n = 1'b1;
        chk("boot_req_vld", 32'(bus.imem_req_valid), 32'h0);
        step();
        chk("first_req_vld", 32'(bus.imem_req_valid), 32'h1);

        // Sequential fetch of 0x0, 0x4, 0x8, one instruction per 3 cycles
        for (int i = 0; i < 3; i++) begin
            chk("seq_req_vld", 32'(bus.imem_req_valid), 32'h1);
            chk("seq_addr",    bus.imem_req_addr,       32'(i * 4));
            chk("seq_req_iv",  32'(bus.instr_valid),    32'h0);
            bus.imem_req_ready = 1'b1;
            step();
            bus.imem_req_ready = 1'b0;
            chk("seq_wait_req", 32'(bus.imem_req_valid), 32'h0);
            chk("seq_wait_iv",  32'(bus.instr_valid),    32'h0);
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'hC0DE_0000 | 32'(i * 4);
            step();
            bus.imem_rsp_valid = 1'b0;
            chk("seq_out_iv",   32'(bus.instr_valid), 32'h1);
            chk("seq_out_data", bus.instr_data,       32'hC0DE_0000 | 32'(i * 4));
            chk("seq_out_pc",   bus.instr_pc,         32'(i * 4));
            bus.instr_ready = 1'b1;
            step();
            bus.instr_ready = 1'b0;
        end

        // Decode stall for 5 cycles at pc 0xC
        chk("stall_addr", bus.imem_req_addr, 32'h0000_000C);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1234_5678;
        step();
        bus.imem_rsp_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_iv",   32'(bus.instr_valid),    32'h1);
            chk("stall_data", bus.instr_data,          32'h1234_5678);
            chk("stall_pc",   bus.instr_pc,            32'h0000_000C);
            chk("stall_req",  32'(bus.imem_req_valid), 32'h0);
            step();
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("stall_next_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("stall_next_addr", bus.imem_req_addr,       32'h0000_0010);

        // Response while in REQ is ignored
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_0000;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("req_rsp_ign_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("req_rsp_ign_iv",   32'(bus.instr_valid),    32'h0);
        chk("req_rsp_ign_addr", bus.imem_req_addr,       32'h0000_0010);

        // Redirect to 0x100 while waiting; stale response 2 cycles later
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0100;
        step();
        bus.redirect_valid = 1'b0;
        chk("wr_drop_req", 32'(bus.imem_req_valid), 32'h0);
        chk("wr_drop_iv",  32'(bus.instr_valid),    32'h0);
        step();
        chk("wr_drop2_req", 32'(bus.imem_req_valid), 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_0010;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("wr_req_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("wr_req_addr", bus.imem_req_addr,       32'h0000_0100);
        chk("wr_req_iv",   32'(bus.instr_valid),    32'h0);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hA000_0100;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("wr_out_pc",   bus.instr_pc,   32'h0000_0100);
        chk("wr_out_data", bus.instr_data, 32'hA000_0100);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        // Redirect to 0x200 in REQ with the request accepted the same cycle
        chk("rr_addr_before", bus.imem_req_addr, 32'h0000_0104);
        bus.imem_req_ready  = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0200;
        step();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("rr_drop_req", 32'(bus.imem_req_valid), 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_0104;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("rr_req_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("rr_req_addr", bus.imem_req_addr,       32'h0000_0200);
        chk("rr_req_iv",   32'(bus.instr_valid),    32'h0);

        // Redirect in REQ without acceptance: address moves, stays in REQ
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0300;
        step();
        bus.redirect_valid = 1'b0;
        chk("rn_req_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("rn_req_addr", bus.imem_req_addr,       32'h0000_0300);

        // Redirect and response in the same WAIT cycle: straight back to REQ
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0400;
        bus.imem_rsp_valid  = 1'b1;
        bus.imem_rsp_data   = 32'hDEAD_0300;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        chk("wb_req_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("wb_req_addr", bus.imem_req_addr,       32'h0000_0400);
        chk("wb_req_iv",   32'(bus.instr_valid),    32'h0);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hB000_0400;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("wb_out_pc",   bus.instr_pc,   32'h0000_0400);
        chk("wb_out_data", bus.instr_data, 32'hB000_0400);

        // Redirect in OUT without decode accepting: instruction dropped
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("or_iv",   32'(bus.instr_valid), 32'h0);
        chk("or_addr", bus.imem_req_addr,    32'hFFFF_FFFC);

        // PC wrap from 0xFFFF_FFFC to 0x0
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hE000_FFFC;
        step();
        bus.imem_rsp_valid = 1'b0;
        chk("wrap_out_pc",   bus.instr_pc,   32'hFFFF_FFFC);
        chk("wrap_out_data", bus.instr_data, 32'hE000_FFFC);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("wrap_req_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("wrap_req_addr", bus.imem_req_addr,       32'h0000_0000);

        // Misaligned redirect target 0x102
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0102;
        step();
        bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault", 32'(misalign_fault),     32'h1);
        chk("mis_req",   32'(bus.imem_req_valid), 32'h0);
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mis_halt_req",   32'(bus.imem_req_valid), 32'h0);
            chk("mis_halt_iv",    32'(bus.instr_valid),    32'h0);
            chk("mis_halt_fault", 32'(misalign_fault),     32'h1);
        end
        bus.imem_req_ready = 1'b0;
`else
        chk("mis_req_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("mis_req_addr", bus.imem_req_addr,       32'h0000_0102);
`endif

        // Reset mid-operation, then redirect during BOOT
        rst_n = 1'b0;
        step();
        chk("rst2_req_vld", 32'(bus.imem_req_valid), 32'h0);
        chk("rst2_iv",      32'(bus.instr_valid),    32'h0);
        chk("rst2_addr",    bus.imem_req_addr,       32'h0);
        chk("rst2_data",    bus.instr_data,          32'h0);
        chk("rst2_pc",      bus.instr_pc,            32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst2_fault",   32'(misalign_fault),     32'h0);
`endif
        rst_n = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0040;
        step();
        bus.redirect_valid = 1'b0;
        chk("boot_rd_vld",  32'(bus.imem_req_valid), 32'h1);
        chk("boot_rd_addr", bus.imem_req_addr,       32'h0000_0040);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
